// File: rtl/wb_arbiter_pkg.sv
// Shared constants for the writeback arbiter slice: source indices and
// default datapath widths for the physical register file write port.
package wb_arbiter_pkg;

    localparam int WB_NSRC       = 3;
    localparam int WB_SRC_ALU    = 0;
    localparam int WB_SRC_FPU    = 1;
    localparam int WB_SRC_MEM    = 2;
    localparam int WB_DEPTH      = 2;
    localparam int LEN_PREG_ADDR = 6;
    localparam int LEN_WORD      = 32;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding {addr, data} results of one execution unit.
// Push into a full FIFO and pop from an empty FIFO are ignored; push and pop
// in the same cycle both take effect.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 38
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array: written on accepted push, never reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally on power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers results from NSRC execution units in per-source
// FIFOs and round-robins them onto the single regfile write port.
// Optional feature macro: WB_FWD_EN (forwarding of the write in flight).
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NSRC   = WB_NSRC,
    parameter int DEPTH  = WB_DEPTH,
    parameter int ADDR_W = LEN_PREG_ADDR,
    parameter int DATA_W = LEN_WORD
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NSRC-1:0]          src_valid,
    output logic [NSRC-1:0]          src_ready,
    input  logic [NSRC*ADDR_W-1:0]   src_addr,
    input  logic [NSRC*DATA_W-1:0]   src_data,
    output logic                     wen,
    output logic [ADDR_W-1:0]        ard,
    output logic [DATA_W-1:0]        drd,
`ifdef WB_FWD_EN
    input  logic [ADDR_W-1:0]        fwd_ars1,
    input  logic [ADDR_W-1:0]        fwd_ars2,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [DATA_W-1:0]        fwd_d1,
    output logic [DATA_W-1:0]        fwd_d2,
`endif
    output logic                     busy
);

    localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [NSRC-1:0]             full, empty, pop;
    logic [NSRC-1:0][ADDR_W-1:0] head_addr;
    logic [NSRC-1:0][DATA_W-1:0] head_data;
    logic [SW-1:0]               rr_ptr, gnt_idx, cand;
    logic                        gnt_vld;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        logic [ADDR_W+DATA_W-1:0] head_w;

        wb_fifo #(.DEPTH(DEPTH), .W(ADDR_W+DATA_W)) u_fifo (
            .clk   (clk),
            .rstn  (rstn),
            .push  (src_valid[i]),
            .pop   (pop[i]),
            .din   ({src_addr[i*ADDR_W +: ADDR_W], src_data[i*DATA_W +: DATA_W]}),
            .full  (full[i]),
            .empty (empty[i]),
            .head  (head_w)
        );

        assign head_addr[i] = head_w[ADDR_W+DATA_W-1:DATA_W];
        assign head_data[i] = head_w[DATA_W-1:0];
        assign pop[i]       = gnt_vld && (gnt_idx == SW'(i));
    end

    // Ready depends only on occupancy, so there is no path from grant/valid.
    assign src_ready = ~full;
    assign busy      = ~(&empty);

    // Round-robin scan starting at rr_ptr: first non-empty head wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NSRC; k++) begin
            cand = SW'((int'(rr_ptr) + k) % NSRC);
            if (!gnt_vld && !empty[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Regfile drive: addr 0 entries are popped but never written, port stays zero.
    always_comb begin
        wen = 1'b0;
        ard = '0;
        drd = '0;
        if (gnt_vld && (head_addr[gnt_idx] != '0)) begin
            wen = 1'b1;
            ard = head_addr[gnt_idx];
            drd = head_data[gnt_idx];
        end
    end

    // Pointer moves past the granted source; idle cycles leave it alone.
    always_ff @(posedge clk) begin
        if (!rstn)        rr_ptr <= '0;
        else if (gnt_vld) rr_ptr <= (int'(gnt_idx) == NSRC-1) ? '0 : gnt_idx + 1'b1;
    end

`ifdef WB_FWD_EN
    // Bypass the value being written this cycle, before the regfile holds it.
    always_comb begin
        fwd_hit1 = wen && (fwd_ars1 == ard) && (fwd_ars1 != '0);
        fwd_hit2 = wen && (fwd_ars2 == ard) && (fwd_ars2 != '0);
        fwd_d1   = fwd_hit1 ? drd : '0;
        fwd_d2   = fwd_hit2 ? drd : '0;
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter. Inputs change and outputs are sampled
// on the falling edge; the DUT acts on the rising edge.
module tb_wb_arbiter;

    localparam int NSRC = 3;
    localparam int AW   = 6;
    localparam int DW   = 32;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic [NSRC-1:0]      src_valid = '0;
    logic [NSRC-1:0]      src_ready;
    logic [NSRC*AW-1:0]   src_addr = '0;
    logic [NSRC*DW-1:0]   src_data = '0;
    logic                 wen;
    logic [AW-1:0]        ard;
    logic [DW-1:0]        drd;
    logic                 busy;
`ifdef WB_FWD_EN
    logic [AW-1:0]        fwd_ars1 = '0, fwd_ars2 = '0;
    logic                 fwd_hit1, fwd_hit2;
    logic [DW-1:0]        fwd_d1, fwd_d2;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.NSRC(NSRC), .DEPTH(2), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_addr  (src_addr),
        .src_data  (src_data),
        .wen       (wen),
        .ard       (ard),
        .drd       (drd),
`ifdef WB_FWD_EN
        .fwd_ars1  (fwd_ars1),
        .fwd_ars2  (fwd_ars2),
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_d1    (fwd_d1),
        .fwd_d2    (fwd_d2),
`endif
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        src_valid[i]          = v;
        src_addr[i*AW +: AW]  = a;
        src_data[i*DW +: DW]  = d;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        src_valid = '0;
        rstn      = 1'b0;
        tick();
        rstn      = 1'b1;
    endtask

    initial begin
        int cnt [3];
        int got;

        // reset state
        @(negedge clk);
        do_reset();
        chk("rst_wen",   wen, 1'b0);
        chk("rst_ard",   ard, '0);
        chk("rst_drd",   drd, '0);
        chk("rst_busy",  busy, 1'b0);
        chk("rst_ready", src_ready, 3'b111);

        // 1: single push, visible one edge after accept, written on the next
        set_src(0, 1'b1, 6'd5, 32'hDEAD);
        chk("t1_pre_wen", wen, 1'b0);
        tick();
        set_src(0, 1'b0, '0, '0);
        chk("t1_wen",  wen, 1'b1);
        chk("t1_ard",  ard, 6'd5);
        chk("t1_drd",  drd, 32'hDEAD);
        chk("t1_busy", busy, 1'b1);
        tick();
        chk("t1_wen_after", wen, 1'b0);
        chk("t1_busy_after", busy, 1'b0);

        // 2: all sources saturated -> strict 0,1,2 rotation, 4 writes each
        do_reset();
        cnt = '{0, 0, 0};
        for (int i = 0; i < NSRC; i++) set_src(i, 1'b1, AW'(10 + i), DW'(32'hA0 + i));
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("t2_wen", wen, 1'b1);
            chk("t2_ard", ard, 64'(10 + k % 3));
            chk("t2_drd", drd, 64'(32'hA0 + k % 3));
            if (wen && ard >= 6'd10 && ard <= 6'd12) cnt[int'(ard) - 10]++;
        end
        for (int i = 0; i < NSRC; i++) chk("t2_count", 64'(cnt[i]), 64'd4);
        src_valid = '0;

        // 3: src1 backs up behind others, then drains in order
        do_reset();
        set_src(0, 1'b1, 6'd10, 32'hA0);
        set_src(1, 1'b1, 6'd21, 32'hB1);
        set_src(2, 1'b1, 6'd12, 32'hA2);
        tick();
        chk("t3_ready_one", src_ready[1], 1'b1);
        chk("t3_first_ard", ard, 6'd10);
        set_src(1, 1'b1, 6'd22, 32'hB2);
        tick();
        chk("t3_full", src_ready[1], 1'b0);
        chk("t3_b1_ard", ard, 6'd21);
        chk("t3_b1_drd", drd, 32'hB1);
        set_src(0, 1'b0, '0, '0);
        set_src(2, 1'b0, '0, '0);
        set_src(1, 1'b1, 6'd23, 32'hB3);
        tick();
        chk("t3_ready_again", src_ready[1], 1'b1);
        chk("t3_src2_ard", ard, 6'd12);
        tick();
        set_src(1, 1'b0, '0, '0);
        got = 0;
        for (int k = 0; k < 8; k++) begin
            if (wen && (ard == 6'd22 || ard == 6'd23)) begin
                chk("t3_order_ard", ard, 64'(22 + got));
                chk("t3_order_drd", drd, 64'(32'hB2 + got));
                got++;
            end
            tick();
        end
        chk("t3_drained", 64'(got), 64'd2);
        chk("t3_busy", busy, 1'b0);

        // 4: addr 0 entry is consumed without a write
        do_reset();
        set_src(2, 1'b1, 6'd0, 32'h1234);
        tick();
        set_src(2, 1'b0, '0, '0);
        chk("t4_busy", busy, 1'b1);
        chk("t4_wen",  wen, 1'b0);
        chk("t4_ard",  ard, '0);
        chk("t4_drd",  drd, '0);
        tick();
        chk("t4_busy_after", busy, 1'b0);
        chk("t4_wen_after",  wen, 1'b0);

        // 5: reset mid-operation discards buffered results and rr_ptr
        do_reset();
        for (int i = 0; i < NSRC; i++) set_src(i, 1'b1, AW'(10 + i), DW'(32'hC0 + i));
        tick();
        tick();
        tick();
        chk("t5_busy_pre", busy, 1'b1);
        src_valid = '0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("t5_wen",   wen, 1'b0);
        chk("t5_ard",   ard, '0);
        chk("t5_drd",   drd, '0);
        chk("t5_busy",  busy, 1'b0);
        chk("t5_ready", src_ready, 3'b111);
        tick();
        chk("t5_wen_idle", wen, 1'b0);
        set_src(0, 1'b1, 6'd10, 32'hC0);
        set_src(2, 1'b1, 6'd12, 32'hC2);
        tick();
        src_valid = '0;
        chk("t5_rr_ard", ard, 6'd10);
        tick();
        chk("t5_rr_next", ard, 6'd12);

`ifdef WB_FWD_EN
        // 6: forwarding of the write in flight
        do_reset();
        fwd_ars1 = 6'd7;
        fwd_ars2 = 6'd0;
        chk("t6_idle_hit1", fwd_hit1, 1'b0);
        set_src(0, 1'b1, 6'd7, 32'h55);
        tick();
        set_src(0, 1'b0, '0, '0);
        chk("t6_hit1", fwd_hit1, 1'b1);
        chk("t6_d1",   fwd_d1, 32'h55);
        chk("t6_hit2", fwd_hit2, 1'b0);
        chk("t6_d2",   fwd_d2, '0);
        tick();
        chk("t6_hit1_after", fwd_hit1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
